fib_rec: RTL and testbench

- BCD-digit to seven-segment decoder with a Fibonacci-digit flag and input-monitoring registers.
- Sits between digit-producing logic and a single seven-segment display digit.
- Decode path is purely combinational, so sevenSeg settles within the same clock phase as BCD_in changes.
- Small synchronous monitor records the last valid digit and counts invalid (non-BCD) input cycles.

---
 rtl/fib_rec.sv | 79 +++++++
 tb/tb_fib_rec.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/fib_rec.sv
// rtl/fib_rec.sv - BCD to seven-segment decoder with Fibonacci flag and input monitor
// Optional hex glyphs for codes 10..15 when FIB_REC_HEX_EN is defined.
module fib_rec #(
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [3:0]           BCD_in,
   output logic [6:0]           sevenSeg,
   output logic                 is_fib,
   output logic                 invalid,
   output logic [3:0]           last_valid,
   output logic [ERR_CNT_W-1:0] err_count
);

   logic [3:0]           last_valid_q, last_valid_d;
   logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

   // Segment order {a,b,c,d,e,f,g}, active-high.
   always_comb begin
      sevenSeg = 7'b0000000;
      case (BCD_in)
         4'd0:    sevenSeg = 7'b1111110;
         4'd1:    sevenSeg = 7'b0110000;
         4'd2:    sevenSeg = 7'b1101101;
         4'd3:    sevenSeg = 7'b1111001;
         4'd4:    sevenSeg = 7'b0110011;
         4'd5:    sevenSeg = 7'b1011011;
         4'd6:    sevenSeg = 7'b1011111;
         4'd7:    sevenSeg = 7'b1110000;
         4'd8:    sevenSeg = 7'b1111111;
         4'd9:    sevenSeg = 7'b1111011;
`ifdef FIB_REC_HEX_EN
         4'd10:   sevenSeg = 7'b1110111;
         4'd11:   sevenSeg = 7'b0011111;
         4'd12:   sevenSeg = 7'b1001110;
         4'd13:   sevenSeg = 7'b0111101;
         4'd14:   sevenSeg = 7'b1001111;
         4'd15:   sevenSeg = 7'b1000111;
`endif
         default: sevenSeg = 7'b0000000;
      endcase
   end

   always_comb begin
      is_fib = 1'b0;
      case (BCD_in)
         4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd8: is_fib = 1'b1;
         default:                            is_fib = 1'b0;
      endcase
   end

   assign invalid = (BCD_in > 4'd9);

   // Counter saturates at all-ones so a stuck input never wraps back to a small count.
   always_comb begin
      last_valid_d = last_valid_q;
      err_count_d  = err_count_q;
      if (!invalid) begin
         last_valid_d = BCD_in;
      end else if (err_count_q != {ERR_CNT_W{1'b1}}) begin
         err_count_d = err_count_q + ERR_CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         last_valid_q <= 4'd0;
         err_count_q  <= '0;
      end else begin
         last_valid_q <= last_valid_d;
         err_count_q  <= err_count_d;
      end
   end

   assign last_valid = last_valid_q;
   assign err_count  = err_count_q;

endmodule

// File: tb/tb_fib_rec.sv
// tb/tb_fib_rec.sv - scoreboard bench for fib_rec
module tb_fib_rec;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] BCD_in = 4'd0;
   logic [6:0] sevenSeg;
   logic       is_fib;
   logic       invalid;
   logic [3:0] last_valid;
   logic [7:0] err_count;

   fib_rec #(.ERR_CNT_W(8)) dut (
      .clk(clk),
      .reset(reset),
      .BCD_in(BCD_in),
      .sevenSeg(sevenSeg),
      .is_fib(is_fib),
      .invalid(invalid),
      .last_valid(last_valid),
      .err_count(err_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [6:0] seg;
      logic       fib;
      logic       inv;
      logic [3:0] lv;
      logic [7:0] ec;
      int         idx;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;
   int   step_no = 0;

   logic [3:0] m_lv = 4'd0;
   logic [7:0] m_ec = 8'd0;
   logic [3:0] prev_b = 4'd0;
   logic       prev_r = 1'b0;

   function automatic logic [6:0] seg_of(input logic [3:0] b);
      case (b)
         4'd0: return 7'b1111110;
         4'd1: return 7'b0110000;
         4'd2: return 7'b1101101;
         4'd3: return 7'b1111001;
         4'd4: return 7'b0110011;
         4'd5: return 7'b1011011;
         4'd6: return 7'b1011111;
         4'd7: return 7'b1110000;
         4'd8: return 7'b1111111;
         4'd9: return 7'b1111011;
`ifdef FIB_REC_HEX_EN
         4'd10: return 7'b1110111;
         4'd11: return 7'b0011111;
         4'd12: return 7'b1001110;
         4'd13: return 7'b0111101;
         4'd14: return 7'b1001111;
         4'd15: return 7'b1000111;
`endif
         default: return 7'b0000000;
      endcase
   endfunction

   function automatic logic fib_of(input logic [3:0] b);
      return (b == 4'd0 || b == 4'd1 || b == 4'd2 || b == 4'd3 || b == 4'd5 || b == 4'd8);
   endfunction

   task automatic step(input logic [3:0] b, input logic r);
      exp_t e;
      @(posedge clk);
      if (!prev_r) begin
         m_lv = 4'd0;
         m_ec = 8'd0;
      end else if (prev_b <= 4'd9) begin
         m_lv = prev_b;
      end else if (m_ec != 8'hFF) begin
         m_ec = m_ec + 8'd1;
      end
      #1;
      BCD_in = b;
      reset  = r;
      prev_b = b;
      prev_r = r;
      step_no++;
      e.seg = seg_of(b);
      e.fib = fib_of(b);
      e.inv = (b > 4'd9);
      e.lv  = m_lv;
      e.ec  = m_ec;
      e.idx = step_no;
      exp_q.push_back(e);
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         checks += 5;
         if (sevenSeg !== e.seg) begin
            failures++;
            $display("FAIL seg step=%0d got=%b exp=%b", e.idx, sevenSeg, e.seg);
         end
         if (is_fib !== e.fib) begin
            failures++;
            $display("FAIL is_fib step=%0d got=%b exp=%b", e.idx, is_fib, e.fib);
         end
         if (invalid !== e.inv) begin
            failures++;
            $display("FAIL invalid step=%0d got=%b exp=%b", e.idx, invalid, e.inv);
         end
         if (last_valid !== e.lv) begin
            failures++;
            $display("FAIL last_valid step=%0d got=%0d exp=%0d", e.idx, last_valid, e.lv);
         end
         if (err_count !== e.ec) begin
            failures++;
            $display("FAIL err_count step=%0d got=%0d exp=%0d", e.idx, err_count, e.ec);
         end
      end
   end

   initial begin
      // Reset held two cycles; decode must still follow BCD_in.
      step(4'd9, 1'b0);
      step(4'd4, 1'b0);
      // 7 then 12 for three cycles.
      step(4'd7, 1'b1);
      step(4'd12, 1'b1);
      step(4'd12, 1'b1);
      step(4'd12, 1'b1);
      step(4'd0, 1'b1);
      // Directed sample: last_valid 7, err_count 3 after the sequence above.
      @(negedge clk);
      checks += 2;
      if (last_valid !== 4'd7) begin
         failures++;
         $display("FAIL seq_last_valid got=%0d exp=7", last_valid);
      end
      if (err_count !== 8'd3) begin
         failures++;
         $display("FAIL seq_err_count got=%0d exp=3", err_count);
      end
      // Full code sweep.
      for (int i = 0; i < 16; i++) step(4'(i), 1'b1);
      // Bring err_count to 5, then pulse reset with a live input.
      step(4'd1, 1'b0);
      for (int i = 0; i < 5; i++) step(4'd10, 1'b1);
      step(4'd6, 1'b0);
      step(4'd6, 1'b1);
      step(4'd11, 1'b1);
      // Saturation: 300 cycles of 13.
      for (int i = 0; i < 300; i++) step(4'd13, 1'b1);
      step(4'd2, 1'b1);
      step(4'd14, 1'b1);
      step(4'd5, 1'b1);
      @(negedge clk);
      checks++;
      if (err_count !== 8'd255) begin
         failures++;
         $display("FAIL saturate got=%0d exp=255", err_count);
      end
      for (int t = 0; t < 20 && exp_q.size() > 0; t++) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain pending=%0d exp=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
